// File: rtl/dispatch_n_way16_if.sv
`default_nettype none
// ============================================================================
// dispatch_n_way16_if: input stream, demux drive and per-lane handshake bundle
// Rev 1.0
// ============================================================================
interface dispatch_n_way16_if #(
  parameter int WAYS = 4
);
  localparam int SEL_WIDTH = $clog2(WAYS);

  logic [15:0]          in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          dmx_in;
  logic [SEL_WIDTH-1:0] dmx_sel;
  logic [WAYS-1:0]      lane_valid;
  logic [WAYS-1:0]      lane_ready;
  logic [15:0]          sent_count;

  modport master (
    input  in_data, in_valid, lane_ready,
    output in_ready, dmx_in, dmx_sel, lane_valid, sent_count
  );

  modport slave (
    output in_data, in_valid, lane_ready,
    input  in_ready, dmx_in, dmx_sel, lane_valid, sent_count
  );
endinterface
`default_nettype wire

// File: rtl/dispatch_n_way16.sv
`default_nettype none
// ============================================================================
// dispatch_n_way16: round-robin steering of a 16-bit valid/ready stream onto WAYS lanes
// Rev 1.0
// ============================================================================
module dispatch_n_way16 #(
  parameter int WAYS      = 4,
  parameter bit SKIP_BUSY = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  dispatch_n_way16_if.master bus
);
  localparam int SEL_WIDTH = $clog2(WAYS);
  localparam int PAD_WAYS  = 1 << SEL_WIDTH;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]           state;
  logic [15:0]          word;
  logic [SEL_WIDTH-1:0] lane;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] target;
  logic [SEL_WIDTH-1:0] next_ptr;
  logic [15:0]          count;
  logic [PAD_WAYS-1:0]  ready_pad;
  logic                 full;
  logic                 held_ready;
  logic                 transfer;
  logic                 in_ready;
  logic                 accept;

  // Padding to a power of two keeps every select-width index in range
  assign ready_pad  = PAD_WAYS'(bus.lane_ready);
  assign full       = (state == S_FULL);
  assign held_ready = ready_pad[lane];
  assign transfer   = full && held_ready;
  assign in_ready   = rst_n && (!full || held_ready);
  assign accept     = bus.in_valid && in_ready;

  generate
    if (SKIP_BUSY) begin : g_skip
      localparam int IW = SEL_WIDTH + 1;
      logic          found;
      logic [IW-1:0] idx;

      always_comb begin
        target = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < WAYS; k++) begin
          idx = {1'b0, ptr} + IW'(k);
          if (idx >= IW'(WAYS)) begin
            idx = idx - IW'(WAYS);
          end
          if (!found && ready_pad[idx[SEL_WIDTH-1:0]]) begin
            target = idx[SEL_WIDTH-1:0];
            found  = 1'b1;
          end
        end
      end
    end else begin : g_strict
      assign target = ptr;
    end
  endgenerate

  // Explicit wrap so non-power-of-two lane counts never reach an invalid select
  assign next_ptr = (target == SEL_WIDTH'(WAYS - 1)) ? '0 : target + SEL_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
      word  <= '0;
      lane  <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        state <= S_FULL;
        word  <= bus.in_data;
        lane  <= target;
        ptr   <= next_ptr;
      end else if (transfer) begin
        state <= S_EMPTY;
      end
      if (transfer) begin
        count <= count + 16'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.dmx_in     = full ? word : 16'h0;
  assign bus.dmx_sel    = full ? lane : ptr;
  assign bus.sent_count = count;

  generate
    for (genvar i = 0; i < WAYS; i++) begin : g_lane
      assign bus.lane_valid[i] = full && (lane == SEL_WIDTH'(i));
    end
  endgenerate
endmodule
`default_nettype wire
